vga_fb_writer: RTL and testbench

//  Upstream write bridge for the VGA framebuffer: accepts CPU-side pixel writes over a valid/ready

---
 rtl/vga_fb_writer_if.sv | 23 ++
 rtl/vga_fb_writer.sv | 79 +++++++
 tb/tb_vga_fb_writer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vga_fb_writer_if.sv
// vga_fb_writer_if: CPU write port and framebuffer write port of the VGA framebuffer bridge.
interface vga_fb_writer_if #(parameter int CNT_W = 16);
  logic             bus_valid;
  logic             bus_ready;
  logic [31:0]      bus_addr;
  logic [31:0]      bus_data;
  logic [3:0]       bus_strb;
  logic             fb_we;
  logic [18:0]      fb_addr;
  logic [23:0]      fb_data;
  logic [2:0]       fb_mask;
  logic             fb_ok;
  logic             busy;
  logic [CNT_W-1:0] drop_cnt;
  modport master (
    output bus_valid, bus_addr, bus_data, bus_strb, fb_ok,
    input  bus_ready, fb_we, fb_addr, fb_data, fb_mask, busy, drop_cnt
  );
  modport slave (
    input  bus_valid, bus_addr, bus_data, bus_strb, fb_ok,
    output bus_ready, fb_we, fb_addr, fb_data, fb_mask, busy, drop_cnt
  );
endinterface

// File: rtl/vga_fb_writer.sv
// vga_fb_writer: decodes CPU pixel writes, queues them in a small FIFO and replays them to the framebuffer.
module vga_fb_writer #(
  parameter logic [3:0] BASE_NIBBLE = 4'h5,
  parameter int         H_RES       = 640,
  parameter int         V_RES       = 480,
  parameter int         DEPTH       = 4,
  parameter int         CNT_W       = 16
) (
  input logic              clk,
  input logic              clrn,
  vga_fb_writer_if.slave   io
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [19:0] PIX = 20'(H_RES * V_RES);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t           state_q, state_d;
  logic [45:0]      mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [18:0]      addr_q, addr_d;
  logic [23:0]      data_q, data_d;
  logic [2:0]       mask_q, mask_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             empty, full, xfer, keep, push, pop;
  logic [45:0]      head;
  logic             unused_bits;
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign xfer  = io.bus_valid && !full;
  assign keep  = io.bus_addr[31:28] == BASE_NIBBLE && {1'b0, io.bus_addr[20:2]} < PIX && |io.bus_strb[2:0];
  assign push  = xfer && keep;
  // a new head can be loaded whenever the port is free or the current write completes
  assign pop   = !empty && (state_q == IDLE || io.fb_ok);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign unused_bits = ^{io.bus_addr[27:21], io.bus_addr[1:0], io.bus_data[31:24], io.bus_strb[3]};
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    mask_d   = mask_q;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    drop_d   = (xfer && !keep && ~&drop_q) ? drop_q + 1'b1 : drop_q;
    if (pop) begin
      state_d = WRITE;
      {addr_d, data_d, mask_d} = head;
    end else if (state_q == WRITE && io.fb_ok) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      drop_q   <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {io.bus_addr[20:2], io.bus_data[23:0], io.bus_strb[2:0]};
  end
  assign io.bus_ready = !full;
  assign io.fb_we     = state_q == WRITE;
  assign io.fb_addr   = addr_q;
  assign io.fb_data   = data_q;
  assign io.fb_mask   = mask_q;
  assign io.busy      = !empty || state_q == WRITE;
  assign io.drop_cnt  = drop_q;
endmodule

// File: tb/tb_vga_fb_writer.sv
// tb_vga_fb_writer: directed stimulus with hand-computed expectations for the framebuffer write bridge.
module tb_vga_fb_writer;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  vga_fb_writer_if #(.CNT_W(4)) io();
  vga_fb_writer #(.CNT_W(4)) dut (.clk(clk), .clrn(clrn), .io(io));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    io.bus_valid = v;
    io.bus_addr  = a;
    io.bus_data  = d;
    io.bus_strb  = s;
  endtask
  initial begin
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    io.fb_ok = 1'b0;
    tick;
    tick;
    clrn = 1'b1;
    check("rst_we", io.fb_we, 0);
    check("rst_busy", io.busy, 0);
    check("rst_drop", io.drop_cnt, 0);
    check("rst_addr", io.fb_addr, 0);
    check("rst_data", io.fb_data, 0);
    check("rst_mask", io.fb_mask, 0);
    tick;
    check("rst_ready", io.bus_ready, 1);
    // single write, fb_ok tied high
    io.fb_ok = 1'b1;
    drive(1'b1, 32'h5000_0010, 32'h00AA_BBCC, 4'h7);
    tick;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("t1_lat_we", io.fb_we, 0);
    check("t1_busy", io.busy, 1);
    tick;
    check("t1_we", io.fb_we, 1);
    check("t1_addr", io.fb_addr, 4);
    check("t1_data", io.fb_data, 24'hAABBCC);
    check("t1_mask", io.fb_mask, 3'b111);
    tick;
    check("t1_we_off", io.fb_we, 0);
    check("t1_idle", io.busy, 0);
    // backpressure: one in flight plus four queued
    io.fb_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h5000_0000 | ((10 + i) << 2), 32'h0010_0000 + i, 4'h7);
      tick;
      check($sformatf("t2_ready%0d", i), io.bus_ready, i < 4);
    end
    drive(1'b1, 32'h5000_0000 | (99 << 2), 32'h00DE_AD00, 4'h7);
    tick;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("t2_full_ready", io.bus_ready, 0);
    check("t2_hold_addr", io.fb_addr, 10);
    check("t2_hold_we", io.fb_we, 1);
    io.fb_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_we%0d", i), io.fb_we, 1);
      check($sformatf("t2_addr%0d", i), io.fb_addr, 10 + i);
      check($sformatf("t2_data%0d", i), io.fb_data, 24'h100000 + i);
      tick;
    end
    check("t2_we_end", io.fb_we, 0);
    check("t2_ready_end", io.bus_ready, 1);
    check("t2_busy_end", io.busy, 0);
    // dropped writes and counter saturation
    io.fb_ok = 1'b0;
    drive(1'b1, 32'h4000_0000, 32'h0011_1111, 4'h7);
    tick;
    drive(1'b1, 32'h5012_C000, 32'h0022_2222, 4'h7);
    tick;
    drive(1'b1, 32'h5000_0000, 32'h0033_3333, 4'h8);
    tick;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("t3_we", io.fb_we, 0);
    check("t3_busy", io.busy, 0);
    check("t3_drop3", io.drop_cnt, 3);
    tick;
    check("t3_we_late", io.fb_we, 0);
    drive(1'b1, 32'h4000_0000, 32'h0, 4'h7);
    for (int i = 0; i < 12; i++) tick;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("t3_drop15", io.drop_cnt, 4'hF);
    drive(1'b1, 32'h4000_0000, 32'h0, 4'h7);
    for (int i = 0; i < 3; i++) tick;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("t3_sat", io.drop_cnt, 4'hF);
    // streaming with fb_ok tied high; ignored address bits set
    io.fb_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h5FE0_0003 | ((100 + i) << 2), 32'hFF00_0000 | (32'h010101 * (i + 1)), 4'hF);
      tick;
      if (i >= 1) begin
        check($sformatf("t4_we%0d", i - 1), io.fb_we, 1);
        check($sformatf("t4_addr%0d", i - 1), io.fb_addr, 100 + i - 1);
        check($sformatf("t4_data%0d", i - 1), io.fb_data, 24'h010101 * i);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick;
    check("t4_we7", io.fb_we, 1);
    check("t4_addr7", io.fb_addr, 107);
    check("t4_mask7", io.fb_mask, 3'b111);
    tick;
    check("t4_we_end", io.fb_we, 0);
    // reset with one write in flight and three queued
    io.fb_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h5000_0000 | ((200 + i) << 2), 32'h0000_0100 + i, 4'h7);
      tick;
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    check("t5_pre_we", io.fb_we, 1);
    check("t5_pre_busy", io.busy, 1);
    clrn = 1'b0;
    tick;
    check("t5_we", io.fb_we, 0);
    check("t5_busy", io.busy, 0);
    check("t5_drop", io.drop_cnt, 0);
    check("t5_addr", io.fb_addr, 0);
    clrn = 1'b1;
    io.fb_ok = 1'b1;
    tick;
    tick;
    check("t5_post_we", io.fb_we, 0);
    check("t5_post_busy", io.busy, 0);
    check("t5_post_ready", io.bus_ready, 1);
    // fb_ok ignored while idle; partial mask at last valid pixel index
    tick;
    check("t6_ok_idle_we", io.fb_we, 0);
    check("t6_ok_idle_addr", io.fb_addr, 0);
    io.fb_ok = 1'b0;
    drive(1'b1, 32'h5012_BFFC, 32'h0012_3456, 4'h5);
    tick;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick;
    check("t6_we", io.fb_we, 1);
    check("t6_addr", io.fb_addr, 307199);
    check("t6_data", io.fb_data, 24'h123456);
    check("t6_mask", io.fb_mask, 3'b101);
    tick;
    check("t6_hold_we", io.fb_we, 1);
    io.fb_ok = 1'b1;
    tick;
    check("t6_done_we", io.fb_we, 0);
    check("t6_drop", io.drop_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
